register_file_param: RTL and testbench

Parametrised, clocked multi-port register file. Successor to the fixed 16-bit × 32-entry mode-switched register file. It provides one synchronous write port and two independent combinational read ports, usable in the same cycle. A post-reset clear sequencer zeroes every entry, and per-entry valid bits record which entries have been written since the clear. It sits between the decode stage and the 16-bit adder/ALU datapath and feeds both ALU operands.

---
 rtl/register_file_param_if.sv | 29 ++
 rtl/register_file_param.sv | 116 +++++++++++
 tb/tb_register_file_param.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: one write port, two read ports, ready and write ack.
// Handshake: a write is accepted on the rising edge where wr_en=1, ready=1 and wr_addr<DEPTH;
// wr_en is a single-cycle request with no backpressure, and wr_ack pulses one cycle after acceptance.
interface register_file_param_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [WIDTH-1:0]  rd_data1;
  logic [WIDTH-1:0]  rd_data2;
  logic              rd_valid1;
  logic              rd_valid2;
  logic              ready;
  logic              wr_ack;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, rd_valid1, rd_valid2, ready, wr_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, rd_valid1, rd_valid2, ready, wr_ack
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised 1W/2R register file with post-reset clear sequencer and per-entry valid bits.
// Define RF_BYPASS_EN to forward same-cycle write data to a matching read port.
module register_file_param #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_file_param_if.slave  bus,
  output logic                  dbgState
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH-1);

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] clrCntQ, clrCntD;
  logic [DEPTH-1:0]  validQ;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              ackQ;
  logic              wrAccept;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [WIDTH-1:0]  memWdata;

  // Zero-extended compare keeps DEPTH == 2**ADDR_W from wrapping to zero.
  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_EXT;
  endfunction

  always_comb begin
    stateD   = stateQ;
    clrCntD  = clrCntQ;
    wrAccept = 1'b0;
    memWe    = 1'b0;
    memAddr  = bus.wr_addr;
    memWdata = bus.wr_data;
    case (stateQ)
      CLEAR: begin
        memWe    = 1'b1;
        memAddr  = clrCntQ;
        memWdata = '0;
        clrCntD  = clrCntQ + ADDR_W'(1);
        if (clrCntQ == LAST_IDX) begin
          stateD  = RUN;
          clrCntD = '0;
        end
      end
      RUN: begin
        wrAccept = bus.wr_en && inRange(bus.wr_addr);
        memWe    = wrAccept;
      end
      default: stateD = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= CLEAR;
      clrCntQ <= '0;
      ackQ    <= 1'b0;
      validQ  <= '0;
    end else begin
      stateQ  <= stateD;
      clrCntQ <= clrCntD;
      ackQ    <= wrAccept;
      if (wrAccept) validQ[bus.wr_addr] <= 1'b1;
    end
  end

  // Array has no reset; the clear sequence is what brings it to a known state.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWdata;
  end

  always_comb begin
    bus.rd_data1  = '0;
    bus.rd_valid1 = 1'b0;
    if (stateQ == RUN && inRange(bus.rd_addr1)) begin
      bus.rd_data1  = mem[bus.rd_addr1];
      bus.rd_valid1 = validQ[bus.rd_addr1];
`ifdef RF_BYPASS_EN
      if (wrAccept && bus.rd_addr1 == bus.wr_addr) begin
        bus.rd_data1  = bus.wr_data;
        bus.rd_valid1 = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    bus.rd_data2  = '0;
    bus.rd_valid2 = 1'b0;
    if (stateQ == RUN && inRange(bus.rd_addr2)) begin
      bus.rd_data2  = mem[bus.rd_addr2];
      bus.rd_valid2 = validQ[bus.rd_addr2];
`ifdef RF_BYPASS_EN
      if (wrAccept && bus.rd_addr2 == bus.wr_addr) begin
        bus.rd_data2  = bus.wr_data;
        bus.rd_valid2 = 1'b1;
      end
`endif
    end
  end

  assign bus.ready  = (stateQ == RUN);
  assign bus.wr_ack = ackQ;
  assign dbgState   = stateQ;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a 32-entry and a 24-entry instance driven with identical stimulus,
// checked against a behavioural model through an expected-result queue.
module tb_register_file_param;

  localparam int SEG_W = 36;
  localparam int SB_W  = 2 * SEG_W;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic dbg32, dbg24;

  register_file_param_if #(.WIDTH(16), .ADDR_W(5)) bus32 ();
  register_file_param_if #(.WIDTH(16), .ADDR_W(5)) bus24 ();

  register_file_param #(.WIDTH(16), .DEPTH(32), .ADDR_W(5)) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus32.slave),
    .dbgState (dbg32)
  );

  register_file_param #(.WIDTH(16), .DEPTH(24), .ADDR_W(5)) dut24 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus24.slave),
    .dbgState (dbg24)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  logic [15:0]     mData  [2][32];
  logic            mValid [2][32];
  int              mCnt   [2];
  bit              mRun   [2];
  bit              mAck   [2];
  logic [SB_W-1:0] exp_q[$];
  int              nCompared;
  int              nMismatched;

  function automatic int depthOf(input int i);
    return (i == 0) ? 32 : 24;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] expRead(input int i, input logic [4:0] ra, input logic we,
                                          input logic [4:0] wa, input logic [15:0] wd);
    if (!mRun[i] || int'(ra) >= depthOf(i)) return '0;
    if (BYPASS && we && int'(wa) < depthOf(i) && wa == ra) return {1'b1, wd};
    return {mValid[i][ra], mData[i][ra]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mRun[i] = 1'b0;
      mCnt[i] = 0;
      mAck[i] = 1'b0;
      for (int j = 0; j < 32; j++) mValid[i][j] = 1'b0;
    end
  endtask

  task automatic modelEdge(input logic we, input logic [4:0] wa, input logic [15:0] wd);
    for (int i = 0; i < 2; i++) begin
      if (!mRun[i]) begin
        mData[i][mCnt[i]] = '0;
        mAck[i] = 1'b0;
        if (mCnt[i] == depthOf(i) - 1) begin
          mRun[i] = 1'b1;
          mCnt[i] = 0;
        end else begin
          mCnt[i]++;
        end
      end else begin
        mAck[i] = we && (int'(wa) < depthOf(i));
        if (mAck[i]) begin
          mData[i][wa]  = wd;
          mValid[i][wa] = 1'b1;
        end
      end
    end
  endtask

  task automatic compareSeg(input string name, input logic [SEG_W-1:0] e,
                            input logic ack, input logic rdy, input logic v1,
                            input logic [15:0] d1, input logic v2, input logic [15:0] d2);
    checkVal({name, ".wr_ack"},    32'(ack), 32'(e[35]));
    checkVal({name, ".ready"},     32'(rdy), 32'(e[34]));
    checkVal({name, ".rd_valid1"}, 32'(v1),  32'(e[33]));
    checkVal({name, ".rd_data1"},  32'(d1),  32'(e[32:17]));
    checkVal({name, ".rd_valid2"}, 32'(v2),  32'(e[16]));
    checkVal({name, ".rd_data2"},  32'(d2),  32'(e[15:0]));
  endtask

  // ---------------- driver ----------------
  task automatic driveInputs(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                             input logic [4:0] ra1, input logic [4:0] ra2);
    bus32.wr_en = we;  bus32.wr_addr = wa;  bus32.wr_data = wd;
    bus32.rd_addr1 = ra1;  bus32.rd_addr2 = ra2;
    bus24.wr_en = we;  bus24.wr_addr = wa;  bus24.wr_data = wd;
    bus24.rd_addr1 = ra1;  bus24.rd_addr2 = ra2;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic runCycle(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                          input logic [4:0] ra1, input logic [4:0] ra2);
    logic [SB_W-1:0] e;
    driveInputs(we, wa, wd, ra1, ra2);
    exp_q.push_back({mAck[0], mRun[0], expRead(0, ra1, we, wa, wd), expRead(0, ra2, we, wa, wd),
                     mAck[1], mRun[1], expRead(1, ra1, we, wa, wd), expRead(1, ra2, we, wa, wd)});
    @(negedge clk);
    e = exp_q.pop_front();
    compareSeg("d32", e[SB_W-1:SEG_W], bus32.wr_ack, bus32.ready, bus32.rd_valid1,
               bus32.rd_data1, bus32.rd_valid2, bus32.rd_data2);
    compareSeg("d24", e[SEG_W-1:0], bus24.wr_ack, bus24.ready, bus24.rd_valid1,
               bus24.rd_data1, bus24.rd_valid2, bus24.rd_data2);
    @(posedge clk);
    modelEdge(we, wa, wd);
    #1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkVal({name, ".ready32"},  32'(bus32.ready),     32'd0);
    checkVal({name, ".ack32"},    32'(bus32.wr_ack),    32'd0);
    checkVal({name, ".valid32"},  32'(bus32.rd_valid1), 32'd0);
    checkVal({name, ".data32"},   32'(bus32.rd_data1),  32'd0);
    checkVal({name, ".ready24"},  32'(bus24.ready),     32'd0);
    checkVal({name, ".ack24"},    32'(bus24.wr_ack),    32'd0);
    checkVal({name, ".state32"},  32'(dbg32),           32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    driveInputs(1'b0, 5'd0, 16'h0, 5'd0, 5'd0);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Clear phase with writes requested: none may land or be acked.
    for (int k = 0; k < 32; k++)
      runCycle(1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)));

    for (int k = 0; k < 16; k++)
      runCycle(1'b0, 5'd0, 16'h0, 5'(2 * k), 5'(2 * k + 1));

    runCycle(1'b1, 5'd0, 16'h1232, 5'd0, 5'd1);
    runCycle(1'b1, 5'd1, 16'h1263, 5'd0, 5'd1);
    runCycle(1'b0, 5'd0, 16'h0,    5'd0, 5'd1);
    runCycle(1'b0, 5'd0, 16'h0,    5'd0, 5'd1);

    // Same-cycle write and read of address 2.
    runCycle(1'b1, 5'd2, 16'hA06B, 5'd2, 5'd3);
    runCycle(1'b0, 5'd0, 16'h0,    5'd2, 5'd2);

    // Address 30 is in range for 32 entries, out of range for 24.
    runCycle(1'b1, 5'd30, 16'h5A5A, 5'd30, 5'd29);
    runCycle(1'b0, 5'd0,  16'h0,    5'd30, 5'd23);

    runCycle(1'b1, 5'd5, 16'hFFFF, 5'd5, 5'd5);
    runCycle(1'b0, 5'd0, 16'h0,    5'd5, 5'd5);

    runCycle(1'b1, 5'd7, 16'h1111, 5'd7, 5'd6);
    runCycle(1'b1, 5'd7, 16'h2222, 5'd7, 5'd6);
    runCycle(1'b0, 5'd0, 16'h0,    5'd7, 5'd7);

    for (int k = 0; k < 200; k++)
      runCycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // Reset in the middle of RUN, right after a write that would otherwise be acked.
    runCycle(1'b1, 5'd3, 16'h00FF, 5'd3, 5'd3);
    driveInputs(1'b0, 5'd0, 16'h0, 5'd3, 5'd3);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++)
      runCycle(1'b0, 5'd0, 16'h0, 5'd3, 5'($urandom_range(0, 31)));
    runCycle(1'b0, 5'd0, 16'h0, 5'd3, 5'd3);
    runCycle(1'b1, 5'd3, 16'hBEEF, 5'd3, 5'd4);
    runCycle(1'b0, 5'd0, 16'h0,    5'd3, 5'd4);

    checkVal("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
